// File: rtl/turf_event_pkg.sv
// Shared definitions for the TURF event data transmitter: FSM states,
// fragment-header field layout and qword sizing.
package turf_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_FRAGHDR,
    ST_DATA,
    ST_DROP
  } tx_state_e;

  localparam int QWORD_BYTES    = 8;
  localparam int FH_EVNUM_LSB   = 48;
  localparam int FH_FRAGIDX_LSB = 32;
  localparam int FH_LAST_BIT    = 31;
  localparam int FH_COUNT_LSB   = 0;

  function automatic logic [63:0] fragHdrWord(input logic [15:0] evNum,
                                              input logic [15:0] fragIdx,
                                              input logic        last,
                                              input logic [15:0] count);
    logic [63:0] w;
    w = '0;
    w[FH_EVNUM_LSB +: 16]   = evNum;
    w[FH_FRAGIDX_LSB +: 16] = fragIdx;
    w[FH_LAST_BIT]          = last;
    w[FH_COUNT_LSB +: 16]   = count;
    return w;
  endfunction

endpackage

// File: rtl/turf_event_tx_port_buffer.sv
// Fragment buffer: simple dual-port RAM with one write port and a registered
// read port (one cycle read latency).
module turf_frag_buffer #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [63:0]          wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [63:0]          rd_data_o
);

  logic [63:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/turf_event_tx_port.sv
// Splits each incoming event into buffered UDP fragments, emitting a UDP header,
// a fragment-header qword and the payload; drops events while the channel is closed.
module turf_event_tx_port
  import turf_event_pkg::*;
#(
  parameter int BUF_ADDR_BITS = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] s_event_tdata,
  input  logic        s_event_tvalid,
  output logic        s_event_tready,
  input  logic        s_event_tlast,
  output logic [63:0] m_udphdr_tdata,
  output logic        m_udphdr_tvalid,
  input  logic        m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tvalid,
  input  logic        m_udpdata_tready,
  output logic        m_udpdata_tlast,
  input  logic [9:0]  nfragment_count_i,
  input  logic [31:0] event_ip_i,
  input  logic [15:0] event_port_i,
  input  logic        event_open_i,
  output logic [15:0] event_number_o,
  output logic [15:0] dropped_count_o
);

  tx_state_e   state_q;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic [9:0]  nfrag_q;
  logic [9:0]  count_q;
  logic [9:0]  rdPtr_q;
  logic [9:0]  rdAddr_d;
  logic        last_q;
  logic [15:0] fragIdx_q;
  logic [15:0] eventNum_q;
  logic [15:0] dropped_q;
  logic        evReady_q;
  logic        hdrValid_q;
  logic [63:0] hdrData_q;
  logic        dataValid_q;
  logic        dataLast_q;
  logic [63:0] fragHdr_q;
  logic [63:0] rdData;
  logic        inBeat;
  logic        hdrFire;
  logic        dataFire;

  assign inBeat   = s_event_tvalid && evReady_q;
  assign hdrFire  = hdrValid_q && m_udphdr_tready;
  assign dataFire = dataValid_q && m_udpdata_tready;

  // Read address runs one qword ahead on each handshake so the RAM latency is hidden.
  always_comb begin
    rdAddr_d = '0;
    if (state_q == ST_DATA) rdAddr_d = dataFire ? rdPtr_q + 10'd1 : rdPtr_q;
  end

  turf_frag_buffer #(
    .ADDR_BITS (BUF_ADDR_BITS)
  ) u_buffer (
    .clk_i     (aclk),
    .wr_en_i   (inBeat && (state_q == ST_FILL)),
    .wr_addr_i (BUF_ADDR_BITS'(count_q)),
    .wr_data_i (s_event_tdata),
    .rd_addr_i (BUF_ADDR_BITS'(rdAddr_d)),
    .rd_data_o (rdData)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      ip_q        <= '0;
      port_q      <= '0;
      nfrag_q     <= 10'd1;
      count_q     <= '0;
      rdPtr_q     <= '0;
      last_q      <= 1'b0;
      fragIdx_q   <= '0;
      eventNum_q  <= '0;
      dropped_q   <= '0;
      evReady_q   <= 1'b0;
      hdrValid_q  <= 1'b0;
      hdrData_q   <= '0;
      dataValid_q <= 1'b0;
      dataLast_q  <= 1'b0;
      fragHdr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_event_tvalid) begin
            evReady_q <= 1'b1;
            if (event_open_i) begin
              ip_q      <= event_ip_i;
              port_q    <= event_port_i;
              nfrag_q   <= (nfragment_count_i == 10'd0) ? 10'd1 : nfragment_count_i;
              fragIdx_q <= '0;
              count_q   <= '0;
              state_q   <= ST_FILL;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_FILL: begin
          if (inBeat) begin
            count_q <= count_q + 10'd1;
            if ((count_q + 10'd1 == nfrag_q) || s_event_tlast) begin
              last_q     <= s_event_tlast;
              evReady_q  <= 1'b0;
              hdrValid_q <= 1'b1;
              hdrData_q  <= {ip_q, port_q, 16'((32'(count_q) + 32'd2) * QWORD_BYTES)};
              state_q    <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (hdrFire) begin
            hdrValid_q  <= 1'b0;
            dataValid_q <= 1'b1;
            dataLast_q  <= 1'b0;
            fragHdr_q   <= fragHdrWord(eventNum_q, fragIdx_q, last_q, 16'(count_q));
            rdPtr_q     <= '0;
            state_q     <= ST_FRAGHDR;
          end
        end
        ST_FRAGHDR: begin
          if (dataFire) begin
            dataLast_q <= (count_q == 10'd1);
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          rdPtr_q <= rdAddr_d;
          if (dataFire) begin
            if (dataLast_q) begin
              dataValid_q <= 1'b0;
              dataLast_q  <= 1'b0;
              rdPtr_q     <= '0;
              count_q     <= '0;
              if (last_q) begin
                eventNum_q <= eventNum_q + 16'd1;
                state_q    <= ST_IDLE;
              end else begin
                fragIdx_q <= fragIdx_q + 16'd1;
                evReady_q <= 1'b1;
                state_q   <= ST_FILL;
              end
            end else begin
              dataLast_q <= (rdPtr_q + 10'd2 == count_q);
            end
          end
        end
        ST_DROP: begin
          if (inBeat && s_event_tlast) begin
            if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
            evReady_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_event_tready   = evReady_q;
  assign m_udphdr_tdata   = hdrData_q;
  assign m_udphdr_tvalid  = hdrValid_q;
  assign m_udpdata_tdata  = (state_q == ST_DATA) ? rdData : fragHdr_q;
  assign m_udpdata_tkeep  = 8'hFF;
  assign m_udpdata_tvalid = dataValid_q;
  assign m_udpdata_tlast  = dataLast_q;
  assign event_number_o   = eventNum_q;
  assign dropped_count_o  = dropped_q;

endmodule

// File: tb/tb_turf_event_tx_port.sv
// Scoreboard bench for turf_event_tx_port: a fragmentation model queues the
// expected headers and payload qwords; a negedge monitor pops and compares them.
module tb_turf_event_tx_port;

  logic        aclk;
  logic        areset;
  logic [63:0] s_event_tdata;
  logic        s_event_tvalid;
  logic        s_event_tready;
  logic        s_event_tlast;
  logic [63:0] m_udphdr_tdata;
  logic        m_udphdr_tvalid;
  logic        m_udphdr_tready;
  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tvalid;
  logic        m_udpdata_tready;
  logic        m_udpdata_tlast;
  logic [9:0]  nfragment_count_i;
  logic [31:0] event_ip_i;
  logic [15:0] event_port_i;
  logic        event_open_i;
  logic [15:0] event_number_o;
  logic [15:0] dropped_count_o;

  int assertCount = 0;
  int failCount   = 0;

  logic [63:0] expHdr[$];
  logic [64:0] expData[$];
  logic [15:0] expEvNum = 16'd0;
  logic        monitorEn = 1'b0;
  logic        randReady = 1'b0;

  turf_event_tx_port #(.BUF_ADDR_BITS(10)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_event_tdata     (s_event_tdata),
    .s_event_tvalid    (s_event_tvalid),
    .s_event_tready    (s_event_tready),
    .s_event_tlast     (s_event_tlast),
    .m_udphdr_tdata    (m_udphdr_tdata),
    .m_udphdr_tvalid   (m_udphdr_tvalid),
    .m_udphdr_tready   (m_udphdr_tready),
    .m_udpdata_tdata   (m_udpdata_tdata),
    .m_udpdata_tkeep   (m_udpdata_tkeep),
    .m_udpdata_tvalid  (m_udpdata_tvalid),
    .m_udpdata_tready  (m_udpdata_tready),
    .m_udpdata_tlast   (m_udpdata_tlast),
    .nfragment_count_i (nfragment_count_i),
    .event_ip_i        (event_ip_i),
    .event_port_i      (event_port_i),
    .event_open_i      (event_open_i),
    .event_number_o    (event_number_o),
    .dropped_count_o   (dropped_count_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] payload(input logic [15:0] tag, input int idx);
    return {tag, ~tag, 32'(idx)};
  endfunction

  // Independent fragmentation model: queues every header and data qword expected.
  task automatic pushEventModel(input int len, input int n, input logic [31:0] ip,
                                input logic [15:0] port, input logic [15:0] tag);
    int nEff = (n == 0) ? 1 : n;
    int rem  = len;
    int fi   = 0;
    int idx  = 0;
    while (rem > 0) begin
      int   c     = (rem < nEff) ? rem : nEff;
      logic lastF = (rem == c);
      expHdr.push_back({ip, port, 16'((c + 1) * 8)});
      expData.push_back({1'b0, expEvNum, 16'(fi), lastF, 15'b0, 16'(c)});
      for (int k = 0; k < c; k++) begin
        expData.push_back({(k == c - 1), payload(tag, idx)});
        idx++;
      end
      rem -= c;
      fi++;
    end
    expEvNum++;
  endtask

  task automatic applyStimulus(input int len, input logic [15:0] tag, input int changeAt);
    int waited;
    @(posedge aclk);
    #1;
    for (int i = 0; i < len; i++) begin
      if (i == changeAt) begin
        event_open_i      = 1'b0;
        nfragment_count_i = 10'd2;
        event_ip_i        = 32'hDEADBEEF;
        event_port_i      = 16'h1111;
      end
      s_event_tdata  = payload(tag, i);
      s_event_tlast  = (i == len - 1);
      s_event_tvalid = 1'b1;
      waited = 0;
      @(negedge aclk);
      while (!s_event_tready && waited < 5000) begin
        @(negedge aclk);
        waited++;
      end
      if (waited >= 5000) begin
        checkOutput("in_timeout", {127'b0, s_event_tready}, 128'd1);
        break;
      end
      @(posedge aclk);
      #1;
    end
    s_event_tvalid = 1'b0;
    s_event_tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expData.size() != 0 || expHdr.size() != 0) && n < 20000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 20000) checkOutput("drain_timeout", 128'(expData.size()), 128'd0);
    repeat (20) @(negedge aclk);
  endtask

  always begin
    @(posedge aclk);
    #1;
    if (randReady) begin
      m_udpdata_tready = ($urandom_range(0, 3) != 0);
      m_udphdr_tready  = ($urandom_range(0, 1) != 0);
    end else begin
      m_udpdata_tready = 1'b1;
      m_udphdr_tready  = 1'b1;
    end
  end

  logic        hdrStall  = 1'b0;
  logic        dataStall = 1'b0;
  logic [63:0] hdrPrev;
  logic [64:0] dataPrev;

  always @(negedge aclk) begin
    if (monitorEn) begin
      if (hdrStall) checkOutput("hdr_stable", {m_udphdr_tvalid, m_udphdr_tdata}, {1'b1, hdrPrev});
      if (dataStall)
        checkOutput("data_stable", {m_udpdata_tvalid, m_udpdata_tlast, m_udpdata_tdata}, {1'b1, dataPrev});
      if (m_udphdr_tvalid && m_udphdr_tready) begin
        if (expHdr.size() == 0) checkOutput("hdr_unexpected", {127'b0, m_udphdr_tvalid}, 128'd0);
        else checkOutput("hdr", m_udphdr_tdata, expHdr.pop_front());
      end
      if (m_udpdata_tvalid && m_udpdata_tready) begin
        checkOutput("tkeep", m_udpdata_tkeep, 8'hFF);
        if (expData.size() == 0) checkOutput("data_unexpected", {127'b0, m_udpdata_tvalid}, 128'd0);
        else checkOutput("data", {m_udpdata_tlast, m_udpdata_tdata}, expData.pop_front());
      end
      hdrStall  = m_udphdr_tvalid && !m_udphdr_tready;
      hdrPrev   = m_udphdr_tdata;
      dataStall = m_udpdata_tvalid && !m_udpdata_tready;
      dataPrev  = {m_udpdata_tlast, m_udpdata_tdata};
    end else begin
      hdrStall  = 1'b0;
      dataStall = 1'b0;
    end
  end

  initial begin
    int n;
    areset            = 1'b1;
    s_event_tdata     = '0;
    s_event_tvalid    = 1'b0;
    s_event_tlast     = 1'b0;
    nfragment_count_i = 10'd127;
    event_ip_i        = 32'h0A000001;
    event_port_i      = 16'd21603;
    event_open_i      = 1'b0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_hdr_valid", {127'b0, m_udphdr_tvalid}, 128'd0);
    checkOutput("rst_data_valid", {127'b0, m_udpdata_tvalid}, 128'd0);
    checkOutput("rst_in_ready", {127'b0, s_event_tready}, 128'd0);
    checkOutput("rst_tlast", {127'b0, m_udpdata_tlast}, 128'd0);
    checkOutput("rst_tkeep", m_udpdata_tkeep, 8'hFF);
    checkOutput("rst_evnum", event_number_o, 16'd0);
    checkOutput("rst_dropped", dropped_count_o, 16'd0);
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    monitorEn = 1'b1;

    $display("[TB] 300-qword event, N=127");
    event_open_i = 1'b1;
    pushEventModel(300, 127, 32'h0A000001, 16'd21603, 16'h0001);
    applyStimulus(300, 16'h0001, -1);
    waitDrain();
    checkOutput("evnum_after_300", event_number_o, expEvNum);

    $display("[TB] closed channel drop");
    event_open_i = 1'b0;
    applyStimulus(5, 16'h0002, -1);
    repeat (10) @(negedge aclk);
    checkOutput("dropped_1", dropped_count_o, 16'd1);
    checkOutput("evnum_after_drop", event_number_o, expEvNum);

    $display("[TB] 254-qword event, exact multiple of N");
    event_open_i = 1'b1;
    pushEventModel(254, 127, 32'h0A000001, 16'd21603, 16'h0003);
    applyStimulus(254, 16'h0003, -1);
    waitDrain();
    checkOutput("evnum_after_254", event_number_o, expEvNum);

    $display("[TB] 1000-qword event with random backpressure");
    randReady = 1'b1;
    pushEventModel(1000, 127, 32'h0A000001, 16'd21603, 16'h0004);
    applyStimulus(1000, 16'h0004, -1);
    waitDrain();
    randReady = 1'b0;
    checkOutput("evnum_after_1000", event_number_o, expEvNum);

    $display("[TB] control change mid-event");
    nfragment_count_i = 10'd4;
    event_ip_i        = 32'hC0A80005;
    event_port_i      = 16'd5000;
    pushEventModel(10, 4, 32'hC0A80005, 16'd5000, 16'h0005);
    applyStimulus(10, 16'h0005, 3);
    waitDrain();
    checkOutput("evnum_after_change", event_number_o, expEvNum);
    applyStimulus(3, 16'h0006, -1);
    repeat (10) @(negedge aclk);
    checkOutput("dropped_2", dropped_count_o, 16'd2);
    checkOutput("evnum_after_drop2", event_number_o, expEvNum);

    $display("[TB] reset during DATA");
    event_open_i      = 1'b1;
    nfragment_count_i = 10'd8;
    event_ip_i        = 32'h0A000001;
    event_port_i      = 16'd21603;
    pushEventModel(8, 8, 32'h0A000001, 16'd21603, 16'h0007);
    applyStimulus(8, 16'h0007, -1);
    n = 0;
    while (expData.size() > 6 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("in_data_before_reset", {127'b0, m_udpdata_tvalid}, 128'd1);
    @(posedge aclk);
    #1;
    areset    = 1'b1;
    monitorEn = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("post_rst_hdr_valid", {127'b0, m_udphdr_tvalid}, 128'd0);
    checkOutput("post_rst_data_valid", {127'b0, m_udpdata_tvalid}, 128'd0);
    checkOutput("post_rst_in_ready", {127'b0, s_event_tready}, 128'd0);
    checkOutput("post_rst_evnum", event_number_o, 16'd0);
    checkOutput("post_rst_dropped", dropped_count_o, 16'd0);
    expHdr.delete();
    expData.delete();
    expEvNum  = 16'd0;
    monitorEn = 1'b1;

    $display("[TB] fresh event after reset, N=0 treated as 1");
    nfragment_count_i = 10'd0;
    pushEventModel(2, 0, 32'h0A000001, 16'd21603, 16'h0008);
    applyStimulus(2, 16'h0008, -1);
    waitDrain();
    checkOutput("evnum_fresh", event_number_o, expEvNum);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
